// File: rtl/fp_id_extract.sv
// Candidate id extractor: buffers filter-pipeline bit vectors and
// streams out the index of every set bit, lowest first.
module fp_id_extract #(
    parameter int BIT_VEC_SIZE     = 128,
    parameter int BIT_VEC_SIZE_LOG = 7,
    parameter int FIFO_DEPTH       = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [BIT_VEC_SIZE-1:0]     vec_in,
    input  logic                        valid_in,
    output logic                        ready_out,
    output logic [BIT_VEC_SIZE_LOG-1:0] id_out,
    output logic                        id_valid,
    input  logic                        id_ready,
    output logic                        id_last,
    output logic                        id_none,
    output logic                        overflow
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {
        IDLE,
        EMIT
    } state_e;

    state_e                  state_q, state_d;
    logic [BIT_VEC_SIZE-1:0] w_q, w_d;
    logic [BIT_VEC_SIZE-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;

    logic [BIT_VEC_SIZE-1:0]     w_clr;
    logic [BIT_VEC_SIZE_LOG-1:0] lsb_idx;
    logic                        w_zero, w_one, last_beat;
    logic                        fifo_empty, push, pop, beat_done;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_clr      = w_q & (w_q - BIT_VEC_SIZE'(1));
    assign w_zero     = (w_q == '0);
    assign w_one      = !w_zero && (w_clr == '0);
    assign last_beat  = w_zero || w_one;
    assign fifo_empty = (cnt_q == '0);
    assign ready_out  = (cnt_q < CW'(FIFO_DEPTH));
    assign push       = valid_in && ready_out;
    assign beat_done  = (state_q == EMIT) && id_ready;
    assign pop        = !fifo_empty &&
                        ((state_q == IDLE) || (beat_done && last_beat));

    assign id_valid = (state_q == EMIT);
    assign id_out   = lsb_idx;
    assign id_last  = id_valid && last_beat;
    assign id_none  = id_valid && w_zero;
    assign overflow = ovf_q;

    // Priority scan for the lowest set bit of the work vector.
    always_comb begin
        lsb_idx = '0;
        for (int k = BIT_VEC_SIZE - 1; k >= 0; k--) begin
            if (w_q[k]) lsb_idx = BIT_VEC_SIZE_LOG'(k);
        end
    end

    // FSM next state and work-register update; last beat reloads W directly.
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = EMIT;
                    w_d     = mem_q[rd_ptr_q];
                end
            end
            EMIT: begin
                if (beat_done) begin
                    if (!last_beat) begin
                        w_d = w_clr;
                    end else if (!fifo_empty) begin
                        w_d = mem_q[rd_ptr_q];
                    end else begin
                        state_d = IDLE;
                        w_d     = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                w_d     = '0;
            end
        endcase
    end

    // FIFO pointer, occupancy and sticky overflow bookkeeping.
    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        ovf_d = ovf_q || (valid_in && !ready_out);
    end

    // State registers; reset discards W and all buffered vectors.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            w_q      <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            w_q      <= w_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            if (push) mem_q[wr_ptr_q] <= vec_in;
        end
    end

endmodule

// File: tb/tb_fp_id_extract.sv
// Directed self-checking bench for fp_id_extract.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_fp_id_extract;

    logic         clk;
    logic         rst;
    logic [127:0] vec_in;
    logic         valid_in;
    logic         ready_out;
    logic [6:0]   id_out;
    logic         id_valid;
    logic         id_ready;
    logic         id_last;
    logic         id_none;
    logic         overflow;

    int errors = 0;
    int checks = 0;

    fp_id_extract #(
        .BIT_VEC_SIZE(128),
        .BIT_VEC_SIZE_LOG(7),
        .FIFO_DEPTH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .vec_in(vec_in),
        .valid_in(valid_in),
        .ready_out(ready_out),
        .id_out(id_out),
        .id_valid(id_valid),
        .id_ready(id_ready),
        .id_last(id_last),
        .id_none(id_none),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input string tag, input int id, input logic last);
        chk({tag, "_valid"}, 32'(id_valid), 1);
        chk({tag, "_id"}, 32'(id_out), 32'(id));
        chk({tag, "_last"}, 32'(id_last), 32'(last));
        chk({tag, "_none"}, 32'(id_none), 0);
    endtask

    int exp_ids [2];
    int p;
    logic r;

    initial begin
        rst      = 1'b0;
        vec_in   = '0;
        valid_in = 1'b0;
        id_ready = 1'b0;
        #2;
        chk("rst_ready", 32'(ready_out), 1);
        chk("rst_valid", 32'(id_valid), 0);
        chk("rst_last", 32'(id_last), 0);
        chk("rst_none", 32'(id_none), 0);
        chk("rst_id", 32'(id_out), 0);
        chk("rst_ovf", 32'(overflow), 0);
        @(posedge clk);
        #3 rst = 1'b1;

        // ids 3,64,127 back to back, latency t+1
        id_ready = 1'b1;
        vec_in = '0;
        vec_in[3] = 1'b1;
        vec_in[64] = 1'b1;
        vec_in[127] = 1'b1;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        chk("t1_lat", 32'(id_valid), 0);
        tick();
        beat("t1_b0", 3, 1'b0);
        tick();
        beat("t1_b1", 64, 1'b0);
        tick();
        beat("t1_b2", 127, 1'b1);
        tick();
        chk("t1_end", 32'(id_valid), 0);
        chk("t1_ovf", 32'(overflow), 0);

        // all-zero vector
        vec_in = '0;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        tick();
        chk("t2_valid", 32'(id_valid), 1);
        chk("t2_none", 32'(id_none), 1);
        chk("t2_last", 32'(id_last), 1);
        chk("t2_id", 32'(id_out), 0);
        tick();
        chk("t2_end", 32'(id_valid), 0);

        // overflow: W holds {9} stalled, then {7},{8},{11}
        id_ready = 1'b0;
        vec_in = '0;
        vec_in[9] = 1'b1;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        tick();
        chk("t3_hold", 32'(id_out), 9);
        vec_in = '0;
        vec_in[7] = 1'b1;
        valid_in = 1'b1;
        tick();
        chk("t3_rdy1", 32'(ready_out), 1);
        vec_in = '0;
        vec_in[8] = 1'b1;
        tick();
        chk("t3_rdy2", 32'(ready_out), 0);
        chk("t3_ovf0", 32'(overflow), 0);
        vec_in = '0;
        vec_in[11] = 1'b1;
        tick();
        valid_in = 1'b0;
        chk("t3_ovf1", 32'(overflow), 1);
        id_ready = 1'b1;
        beat("t3_d0", 9, 1'b1);
        tick();
        beat("t3_d1", 7, 1'b1);
        tick();
        beat("t3_d2", 8, 1'b1);
        tick();
        chk("t3_drop", 32'(id_valid), 0);
        chk("t3_sticky", 32'(overflow), 1);
        chk("t3_rdy3", 32'(ready_out), 1);

        // {5} then {0,1}, no bubble
        id_ready = 1'b0;
        vec_in = '0;
        vec_in[5] = 1'b1;
        valid_in = 1'b1;
        tick();
        vec_in = '0;
        vec_in[0] = 1'b1;
        vec_in[1] = 1'b1;
        tick();
        valid_in = 1'b0;
        beat("t4_b0", 5, 1'b1);
        id_ready = 1'b1;
        tick();
        beat("t4_b1", 0, 1'b0);
        tick();
        beat("t4_b2", 1, 1'b1);
        tick();
        chk("t4_end", 32'(id_valid), 0);

        // random stalls on {10,20}
        id_ready = 1'b0;
        vec_in = '0;
        vec_in[10] = 1'b1;
        vec_in[20] = 1'b1;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        tick();
        exp_ids[0] = 10;
        exp_ids[1] = 20;
        p = 0;
        for (int i = 0; i < 60 && p < 2; i++) begin
            beat("t5", exp_ids[p], p == 1);
            r = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            id_ready = r;
            tick();
            if (r) p++;
        end
        chk("t5_count", 32'(p), 2);
        chk("t5_end", 32'(id_valid), 0);

        // reset mid-vector {1,2,3} with {4} queued
        id_ready = 1'b0;
        vec_in = '0;
        vec_in[1] = 1'b1;
        vec_in[2] = 1'b1;
        vec_in[3] = 1'b1;
        valid_in = 1'b1;
        tick();
        vec_in = '0;
        vec_in[4] = 1'b1;
        tick();
        valid_in = 1'b0;
        beat("t6_b0", 1, 1'b0);
        id_ready = 1'b1;
        tick();
        beat("t6_b1", 2, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("t6_valid", 32'(id_valid), 0);
        chk("t6_id", 32'(id_out), 0);
        chk("t6_last", 32'(id_last), 0);
        chk("t6_ovf", 32'(overflow), 0);
        chk("t6_ready", 32'(ready_out), 1);
        @(posedge clk);
        #3 rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t6_ghost", 32'(id_valid), 0);
        end
        vec_in = '0;
        vec_in[6] = 1'b1;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        tick();
        beat("t6_new", 6, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
